// File: rtl/ctr_retire_sync.sv
// Pairs retirement records from two lockstep runs through per-run FIFOs and
// flags desynchronisation (overflow, one-sided timeout, unmatched drain).
module ctr_retire_sync #(
  parameter int REC_W   = 224,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         finish_i,
  input  logic                         valid_1_i,
  input  logic [REC_W-1:0]             rec_1_i,
  input  logic                         valid_2_i,
  input  logic [REC_W-1:0]             rec_2_i,
  output logic                         retire_o,
  output logic [REC_W-1:0]             rec_1_o,
  output logic [REC_W-1:0]             rec_2_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_1_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_2_o,
  output logic [31:0]                  pairs_o,
  output logic                         overflow_o,
  output logic                         desync_o,
  output logic                         done_o,
  output logic [1:0]                   state_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t           state;
  logic [REC_W-1:0] mem_1 [DEPTH];
  logic [REC_W-1:0] mem_2 [DEPTH];
  logic [PW-1:0]    wptr_1, rptr_1, wptr_2, rptr_2;
  logic [TW-1:0]    tcnt;

  logic active, empty_1, empty_2, full_1, full_2, one_nonempty;
  logic pop, push_req_1, push_req_2, ovf_1, ovf_2, push_1, push_2, timeout_hit;
  logic [TW-1:0] tcnt_next;

  assign state_o = state;

  // Pops are always paired; a full FIFO can still accept a push only when it pops in the same cycle.
  always_comb begin
    active       = (state == RUN) || (state == DRAIN);
    empty_1      = (count_1_o == '0);
    empty_2      = (count_2_o == '0);
    full_1       = (count_1_o == CW'(DEPTH));
    full_2       = (count_2_o == CW'(DEPTH));
    one_nonempty = (empty_1 != empty_2);
    pop          = active && enable_i && !empty_1 && !empty_2;
    push_req_1   = (state == RUN) && enable_i && valid_1_i;
    push_req_2   = (state == RUN) && enable_i && valid_2_i;
    ovf_1        = push_req_1 && full_1 && !pop;
    ovf_2        = push_req_2 && full_2 && !pop;
    push_1       = push_req_1 && !ovf_1;
    push_2       = push_req_2 && !ovf_2;
    tcnt_next    = tcnt + TW'(1);
    timeout_hit  = active && enable_i && one_nonempty && !pop && (tcnt_next == TW'(TIMEOUT));
  end

  always_ff @(posedge clk_i) begin
    if (push_1) mem_1[wptr_1] <= rec_1_i;
    if (push_2) mem_2[wptr_2] <= rec_2_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      wptr_1     <= '0;
      rptr_1     <= '0;
      wptr_2     <= '0;
      rptr_2     <= '0;
      count_1_o  <= '0;
      count_2_o  <= '0;
      tcnt       <= '0;
      retire_o   <= 1'b0;
      rec_1_o    <= '0;
      rec_2_o    <= '0;
      pairs_o    <= '0;
      overflow_o <= 1'b0;
      desync_o   <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      retire_o <= pop;
      if (pop) begin
        rec_1_o <= mem_1[rptr_1];
        rec_2_o <= mem_2[rptr_2];
        rptr_1  <= rptr_1 + PW'(1);
        rptr_2  <= rptr_2 + PW'(1);
        pairs_o <= pairs_o + 32'd1;
      end
      if (push_1) wptr_1 <= wptr_1 + PW'(1);
      if (push_2) wptr_2 <= wptr_2 + PW'(1);
      count_1_o <= count_1_o + CW'(push_1) - CW'(pop);
      count_2_o <= count_2_o + CW'(push_2) - CW'(pop);

      if (active) begin
        if (pop || !one_nonempty) tcnt <= '0;
        else                      tcnt <= tcnt_next;
      end

      case (state)
        IDLE: begin
          wptr_1    <= '0;
          rptr_1    <= '0;
          wptr_2    <= '0;
          rptr_2    <= '0;
          count_1_o <= '0;
          count_2_o <= '0;
          tcnt      <= '0;
          // A finished drain parks here with done_o high until enable drops.
          if (done_o) begin
            if (!enable_i) done_o <= 1'b0;
          end else if (enable_i) begin
            state   <= RUN;
            pairs_o <= '0;
          end
        end
        RUN, DRAIN: begin
          if (!enable_i) begin
            state     <= IDLE;
            wptr_1    <= '0;
            rptr_1    <= '0;
            wptr_2    <= '0;
            rptr_2    <= '0;
            count_1_o <= '0;
            count_2_o <= '0;
            tcnt      <= '0;
          end else if (ovf_1 || ovf_2 || timeout_hit) begin
            if (ovf_1 || ovf_2) overflow_o <= 1'b1;
            if (timeout_hit)    desync_o   <= 1'b1;
            state <= ERROR;
          end else if (state == RUN) begin
            if (finish_i) state <= DRAIN;
          end else if (empty_1 && empty_2) begin
            state  <= IDLE;
            done_o <= 1'b1;
          end else if (one_nonempty) begin
            desync_o <= 1'b1;
            state    <= ERROR;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctr_retire_sync.sv
// Scoreboard bench for ctr_retire_sync: stimulus queues expected pairs with
// their retire cycle, a negedge monitor pops and compares every retire pulse.
module tb_ctr_retire_sync;

  localparam int REC_W   = 224;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(DEPTH + 1);

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             enable_i, finish_i, valid_1_i, valid_2_i;
  logic [REC_W-1:0] rec_1_i, rec_2_i;
  logic             retire_o;
  logic [REC_W-1:0] rec_1_o, rec_2_o;
  logic [CW-1:0]    count_1_o, count_2_o;
  logic [31:0]      pairs_o;
  logic             overflow_o, desync_o, done_o;
  logic [1:0]       state_o;

  typedef struct {
    logic [REC_W-1:0] r1;
    logic [REC_W-1:0] r2;
    int               cyc;
  } pair_t;

  pair_t exp_q[$];
  pair_t mon_e;
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  ctr_retire_sync #(.REC_W(REC_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .finish_i(finish_i),
    .valid_1_i(valid_1_i), .rec_1_i(rec_1_i), .valid_2_i(valid_2_i), .rec_2_i(rec_2_i),
    .retire_o(retire_o), .rec_1_o(rec_1_o), .rec_2_o(rec_2_o),
    .count_1_o(count_1_o), .count_2_o(count_2_o), .pairs_o(pairs_o),
    .overflow_o(overflow_o), .desync_o(desync_o), .done_o(done_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: every retire pulse must match the oldest expected pair and its cycle.
  always @(negedge clk_i) begin
    if (rst_ni && retire_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_retire: got rec_1=%0h rec_2=%0h at cycle %0d, expected no retire",
                 rec_1_o, rec_2_o, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (rec_1_o !== mon_e.r1 || rec_2_o !== mon_e.r2 || cyc != mon_e.cyc) begin
          errors++;
          $display("[TB] FAIL retire_pair: got rec_1=%0h rec_2=%0h cycle %0d, expected rec_1=%0h rec_2=%0h cycle %0d",
                   rec_1_o, rec_2_o, cyc, mon_e.r1, mon_e.r2, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic v1, input logic [REC_W-1:0] r1,
                               input logic v2, input logic [REC_W-1:0] r2);
    valid_1_i = v1;
    rec_1_i   = r1;
    valid_2_i = v2;
    rec_2_i   = r2;
    step();
    valid_1_i = 1'b0;
    valid_2_i = 1'b0;
  endtask

  task automatic expectPair(input logic [REC_W-1:0] r1, input logic [REC_W-1:0] r2, input int c);
    pair_t p;
    p.r1  = r1;
    p.r2  = r2;
    p.cyc = c;
    exp_q.push_back(p);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_state"},    64'(state_o), 64'd0);
    checkOutput({tag, "_retire"},   64'(retire_o), 64'd0);
    checkOutput({tag, "_rec_1"},    64'(|rec_1_o), 64'd0);
    checkOutput({tag, "_rec_2"},    64'(|rec_2_o), 64'd0);
    checkOutput({tag, "_count_1"},  64'(count_1_o), 64'd0);
    checkOutput({tag, "_count_2"},  64'(count_2_o), 64'd0);
    checkOutput({tag, "_pairs"},    64'(pairs_o), 64'd0);
    checkOutput({tag, "_overflow"}, 64'(overflow_o), 64'd0);
    checkOutput({tag, "_desync"},   64'(desync_o), 64'd0);
    checkOutput({tag, "_done"},     64'(done_o), 64'd0);
  endtask

  initial begin
    rst_ni    = 1'b0;
    enable_i  = 1'b0;
    finish_i  = 1'b0;
    valid_1_i = 1'b0;
    valid_2_i = 1'b0;
    rec_1_i   = '0;
    rec_2_i   = '0;
    step();
    step();
    checkResetOutputs("reset");
    rst_ni = 1'b1;
    step();

    // Basic pairing: retire two cycles after each balanced push.
    enable_i = 1'b1;
    step();
    checkOutput("basic_state_run", 64'(state_o), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      expectPair(REC_W'(i), REC_W'(i), cyc + 2);
      applyStimulus(1'b1, REC_W'(i), 1'b1, REC_W'(i));
    end
    repeat (4) step();
    checkOutput("basic_pairs", 64'(pairs_o), 64'd3);
    checkOutput("basic_sb_empty", 64'(exp_q.size()), 64'd0);

    // Skew: run 2 lags run 1 by four cycles.
    for (int i = 0; i < 9; i++) begin
      if (i == 5) begin
        checkOutput("skew_count_1_peak", 64'(count_1_o), 64'd5);
        checkOutput("skew_count_2", 64'(count_2_o), 64'd1);
      end
      if (i >= 4) expectPair(REC_W'(32'h10 + i - 4), REC_W'(32'h20 + i - 4), cyc + 2);
      applyStimulus(i < 5, REC_W'(32'h10 + i), i >= 4, REC_W'(32'h20 + i - 4));
    end
    repeat (4) step();
    checkOutput("skew_pairs", 64'(pairs_o), 64'd8);
    checkOutput("skew_overflow", 64'(overflow_o), 64'd0);
    checkOutput("skew_desync", 64'(desync_o), 64'd0);
    checkOutput("skew_count_1_end", 64'(count_1_o), 64'd0);
    checkOutput("skew_sb_empty", 64'(exp_q.size()), 64'd0);

    // Clean drain, then done_o held until enable drops, then pairs_o clears on re-entry.
    for (int i = 0; i < 4; i++) begin
      expectPair(REC_W'(32'h30 + i), REC_W'(32'h30 + i), cyc + 2);
      applyStimulus(1'b1, REC_W'(32'h30 + i), 1'b1, REC_W'(32'h30 + i));
    end
    finish_i = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0);
    finish_i = 1'b0;
    checkOutput("drain_state", 64'(state_o), 64'd2);
    step();
    checkOutput("done_state_idle", 64'(state_o), 64'd0);
    checkOutput("done_flag", 64'(done_o), 64'd1);
    checkOutput("done_pairs", 64'(pairs_o), 64'd12);
    checkOutput("done_desync", 64'(desync_o), 64'd0);
    step();
    checkOutput("done_held_enable_high", 64'(done_o), 64'd1);
    enable_i = 1'b0;
    step();
    checkOutput("done_cleared", 64'(done_o), 64'd0);
    checkOutput("done_cleared_state", 64'(state_o), 64'd0);
    enable_i = 1'b1;
    step();
    checkOutput("rerun_state", 64'(state_o), 64'd1);
    checkOutput("rerun_pairs_cleared", 64'(pairs_o), 64'd0);
    checkOutput("drain_sb_empty", 64'(exp_q.size()), 64'd0);

    // Unmatched drain: run 1 holds two extra records when finish arrives.
    for (int i = 0; i < 2; i++) begin
      expectPair(REC_W'(32'h40 + i), REC_W'(32'h40 + i), cyc + 2);
      applyStimulus(1'b1, REC_W'(32'h40 + i), 1'b1, REC_W'(32'h40 + i));
    end
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, REC_W'(32'h50 + i), 1'b0, '0);
    finish_i = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0);
    finish_i = 1'b0;
    checkOutput("unmatched_drain_state", 64'(state_o), 64'd2);
    step();
    checkOutput("unmatched_state_error", 64'(state_o), 64'd3);
    checkOutput("unmatched_desync", 64'(desync_o), 64'd1);
    checkOutput("unmatched_overflow", 64'(overflow_o), 64'd0);
    checkOutput("unmatched_count_1", 64'(count_1_o), 64'd2);
    checkOutput("unmatched_pairs", 64'(pairs_o), 64'd2);
    checkOutput("unmatched_sb_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-cycle while in ERROR.
    #2;
    rst_ni = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    step();
    rst_ni = 1'b1;

    // Overflow: nine run-1 pushes into an eight-deep FIFO.
    step();
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin
        checkOutput("ovf_pre_state", 64'(state_o), 64'd1);
        checkOutput("ovf_pre_flag", 64'(overflow_o), 64'd0);
        checkOutput("ovf_pre_full", 64'(count_1_o), 64'd8);
      end
      applyStimulus(1'b1, REC_W'(32'h60 + i), 1'b0, '0);
    end
    checkOutput("ovf_flag", 64'(overflow_o), 64'd1);
    checkOutput("ovf_state", 64'(state_o), 64'd3);
    checkOutput("ovf_count_1", 64'(count_1_o), 64'd8);
    checkOutput("ovf_desync", 64'(desync_o), 64'd0);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;

    // Timeout: one record on run 1, run 2 silent.
    step();
    applyStimulus(1'b1, REC_W'(32'h70), 1'b0, '0);
    repeat (15) step();
    checkOutput("timeout_pre_state", 64'(state_o), 64'd1);
    checkOutput("timeout_pre_desync", 64'(desync_o), 64'd0);
    step();
    checkOutput("timeout_desync", 64'(desync_o), 64'd1);
    checkOutput("timeout_state", 64'(state_o), 64'd3);
    checkOutput("timeout_overflow", 64'(overflow_o), 64'd0);
    enable_i = 1'b0;
    step();
    step();
    checkOutput("error_ignores_enable", 64'(state_o), 64'd3);
    checkOutput("error_count_frozen", 64'(count_1_o), 64'd1);
    checkOutput("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
